// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC select encoding,
// default parameter values and the pointer-width helper for the return stack.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_RET,
    SEL_JMP,
    SEL_BR,
    SEL_SEQ
  } pc_sel_e;

  localparam int unsigned PcWDefault       = 10;
  localparam int unsigned StepDefault      = 4;
  localparam int unsigned ResetVecDefault  = 0;
  localparam int unsigned RasDepthDefault  = 4;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control and status bundle between the fetch controller (master) and pc_unit (slave).
interface pc_unit_if #(
  parameter int unsigned PC_W = pc_pkg::PcWDefault
);
  logic            stall;
  logic            branch;
  logic [PC_W-1:0] branch_target;
  logic            jump;
  logic            call;
  logic [PC_W-1:0] jump_target;
  logic            ret;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  logic            misaligned;
  logic            ras_full;
  logic            ras_empty;
  logic            ras_err;

  modport master (
    output stall, branch, branch_target, jump, call, jump_target, ret,
    input  pc, pc_next, misaligned, ras_full, ras_empty, ras_err
  );

  modport slave (
    input  stall, branch, branch_target, jump, call, jump_target, ret,
    output pc, pc_next, misaligned, ras_full, ras_empty, ras_err
  );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack. A push when full overwrites the oldest entry;
// overflow/underflow are single-cycle pulses for the parent to accumulate.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned PC_W  = PcWDefault,
  parameter int unsigned DEPTH = RasDepthDefault
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top_data,
  output logic            full,
  output logic            empty,
  output logic            overflow,
  output logic            underflow
);

  localparam int unsigned PtrW = clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] top_q, top_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0] mem_q [DEPTH];

  assign full      = (cnt_q == CntW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign overflow  = push & full;
  assign underflow = pop & empty;
  assign top_data  = mem_q[top_q];

  // Pointer wraps naturally since DEPTH is a power of two.
  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    if (push) begin
      top_d = top_q + 1'b1;
      if (!full) cnt_d = cnt_q + 1'b1;
    end else if (pop && !empty) begin
      top_d = top_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) mem_q[top_d] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Registered program counter with stall, ret/jump/branch redirect priority,
// call/return via pc_ras, modulo PC+STEP adder and misalignment flag.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned PC_W      = PcWDefault,
  parameter int unsigned STEP      = StepDefault,
  parameter int unsigned RESET_VEC = ResetVecDefault,
  parameter int unsigned RAS_DEPTH = RasDepthDefault
) (
  input  logic       clk,
  input  logic       rst,
  pc_unit_if.slave   bus
);

  localparam logic [PC_W-1:0] StepVal   = PC_W'(STEP);
  localparam logic [PC_W-1:0] AlignMask = PC_W'(STEP - 1);
  localparam logic [PC_W-1:0] ResetVal  = PC_W'(RESET_VEC);

  logic [PC_W-1:0] pc_q, pc_d, pc_inc, ras_top;
  logic            mis_q, mis_d;
  logic            err_q, err_d;
  logic            ras_push, ras_pop, ras_full, ras_empty, ras_ovf, ras_unf;
  pc_sel_e         sel;

  assign pc_inc = pc_q + StepVal;

  // A ret always requests a pop; on an empty stack it falls back to sequential.
  always_comb begin
    sel      = SEL_SEQ;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (bus.stall) begin
      sel = SEL_HOLD;
    end else if (bus.ret) begin
      ras_pop = 1'b1;
      sel     = ras_empty ? SEL_SEQ : SEL_RET;
    end else if (bus.jump) begin
      sel      = SEL_JMP;
      ras_push = bus.call;
    end else if (bus.branch) begin
      sel = SEL_BR;
    end
  end

  always_comb begin
    pc_d  = pc_q;
    mis_d = mis_q;
    unique case (sel)
      SEL_HOLD: pc_d = pc_q;
      SEL_RET:  pc_d = ras_top;
      SEL_JMP:  pc_d = bus.jump_target;
      SEL_BR:   pc_d = bus.branch_target;
      SEL_SEQ:  pc_d = pc_inc;
      default:  pc_d = pc_q;
    endcase
    if (sel != SEL_HOLD) mis_d = |(pc_d & AlignMask);
    err_d = err_q | ras_ovf | ras_unf;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q  <= ResetVal;
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
      err_q <= err_d;
    end
  end

  pc_ras #(
    .PC_W  (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top_data  (ras_top),
    .full      (ras_full),
    .empty     (ras_empty),
    .overflow  (ras_ovf),
    .underflow (ras_unf)
  );

  assign bus.pc         = pc_q;
  assign bus.pc_next    = pc_inc;
  assign bus.misaligned = mis_q;
  assign bus.ras_full   = ras_full;
  assign bus.ras_empty  = ras_empty;
  assign bus.ras_err    = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios with literal expectations plus random
// stimulus, all outputs compared every cycle against a queue-based reference.
module tb_pc_unit;

  localparam int PC_W = 10;
  localparam int STEP = 4;
  localparam int RVEC = 0;
  localparam int DEP  = 4;
  localparam int MODV = 1 << PC_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   chk_en = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  pc_unit_if #(.PC_W(PC_W)) bus ();

  pc_unit #(
    .PC_W      (PC_W),
    .STEP      (STEP),
    .RESET_VEC (RVEC),
    .RAS_DEPTH (DEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  // Reference model: architectural state kept as plain integers and a queue.
  int m_pc = 0;
  bit m_mis = 0;
  bit m_err = 0;
  int m_ras[$];

  always @(posedge clk) begin
    int nxt, nw;
    if (!rst) begin
      m_pc = RVEC; m_mis = 0; m_err = 0; m_ras.delete();
    end else if (!bus.stall) begin
      nxt = (m_pc + STEP) % MODV;
      if (bus.ret) begin
        if (m_ras.size() > 0) nw = m_ras.pop_back();
        else begin nw = nxt; m_err = 1; end
      end else if (bus.jump) begin
        nw = int'(bus.jump_target);
        if (bus.call) begin
          if (m_ras.size() == DEP) begin void'(m_ras.pop_front()); m_err = 1; end
          m_ras.push_back(nxt);
        end
      end else if (bus.branch) begin
        nw = int'(bus.branch_target);
      end else begin
        nw = nxt;
      end
      m_pc  = nw;
      m_mis = (nw % STEP) != 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", int'(bus.pc), m_pc);
      check("pc_next", int'(bus.pc_next), (m_pc + STEP) % MODV);
      check("misaligned", int'(bus.misaligned), int'(m_mis));
      check("ras_full", int'(bus.ras_full), int'(m_ras.size() == DEP));
      check("ras_empty", int'(bus.ras_empty), int'(m_ras.size() == 0));
      check("ras_err", int'(bus.ras_err), int'(m_err));
    end
  end

  task automatic idle();
    bus.stall = 0; bus.branch = 0; bus.jump = 0; bus.call = 0; bus.ret = 0;
    bus.branch_target = '0; bus.jump_target = '0;
  endtask

  // Apply one cycle of controls, then return 1 time unit after the edge.
  task automatic drive(input bit s, input bit b, input bit j, input bit c, input bit r,
                       input int bt, input int jt);
    bus.stall = s; bus.branch = b; bus.jump = j; bus.call = c; bus.ret = r;
    bus.branch_target = PC_W'(bt); bus.jump_target = PC_W'(jt);
    @(posedge clk); #1;
    idle();
  endtask

  task automatic step();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
  endtask

  initial begin
    idle();
    rst = 0;
    @(posedge clk); #1;
    chk_en = 1;
    rst = 1;

    // Reset state and free-running sequence
    check("rst_pc", int'(bus.pc), 0);
    check("rst_empty", int'(bus.ras_empty), 1);
    check("rst_full", int'(bus.ras_full), 0);
    check("rst_err", int'(bus.ras_err), 0);
    check("rst_mis", int'(bus.misaligned), 0);
    step(); check("seq1", int'(bus.pc), 4);
    step(); check("seq2", int'(bus.pc), 8);
    step(); check("seq3", int'(bus.pc), 12);
    check("seq3_next", int'(bus.pc_next), 16);
    do_reset(); check("midrst_pc", int'(bus.pc), 0);

    // Wrap at the top of the address space
    drive(0, 1, 0, 0, 0, 1020, 0); check("br1020", int'(bus.pc), 1020);
    check("next_wrap", int'(bus.pc_next), 0);
    step(); check("wrap", int'(bus.pc), 0);

    // Stall holds and ignores branch
    step(); step(); check("pre_stall", int'(bus.pc), 8);
    drive(1, 1, 0, 0, 0, 100, 0); check("stall1", int'(bus.pc), 8);
    drive(1, 1, 0, 0, 0, 100, 0); check("stall2", int'(bus.pc), 8);

    // Jump beats branch; misaligned target
    do_reset(); repeat (4) step(); check("at16", int'(bus.pc), 16);
    drive(0, 1, 1, 0, 0, 100, 200); check("jmp_wins", int'(bus.pc), 200);
    drive(0, 1, 0, 0, 0, 3, 0); check("br3", int'(bus.pc), 3);
    check("br3_mis", int'(bus.misaligned), 1);
    step(); check("seq7", int'(bus.pc), 7);
    check("seq7_mis", int'(bus.misaligned), 1);

    // Call / return pair
    do_reset(); step(); step();
    drive(0, 0, 1, 1, 0, 0, 40); check("call40", int'(bus.pc), 40);
    drive(0, 0, 1, 1, 0, 0, 80); check("call80", int'(bus.pc), 80);
    drive(0, 0, 0, 0, 1, 0, 0); check("ret44", int'(bus.pc), 44);
    drive(0, 0, 0, 0, 1, 0, 0); check("ret12", int'(bus.pc), 12);
    check("ret_empty", int'(bus.ras_empty), 1);

    // Overflow: five pushes, LIFO of the last four
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(0, 0, 1, 1, 0, 0, 100 * i);
      if (i == 4) begin
        check("full4", int'(bus.ras_full), 1);
        check("err4", int'(bus.ras_err), 0);
      end
    end
    check("err5", int'(bus.ras_err), 1);
    for (int i = 4; i >= 1; i--) begin
      drive(0, 0, 0, 0, 1, 0, 0);
      check("lifo", int'(bus.pc), 100 * i + 4);
    end
    check("lifo_empty", int'(bus.ras_empty), 1);

    // Underflow is sticky
    do_reset(); repeat (5) step(); check("at20", int'(bus.pc), 20);
    drive(0, 0, 0, 0, 1, 0, 0); check("unf_pc", int'(bus.pc), 24);
    check("unf_err", int'(bus.ras_err), 1);
    repeat (3) step(); check("err_sticky", int'(bus.ras_err), 1);
    do_reset(); check("err_clr", int'(bus.ras_err), 0);

    // Random traffic, checked by the per-cycle compare process
    for (int n = 0; n < 3000; n++) begin
      int bt, jt;
      bt = $urandom_range(MODV - 1);
      jt = $urandom_range(MODV - 1);
      if ($urandom_range(3) != 0) begin bt = bt & ~(STEP - 1); jt = jt & ~(STEP - 1); end
      rst = ($urandom_range(79) != 0);
      drive($urandom_range(7) == 0, $urandom_range(3) == 0, $urandom_range(2) == 0,
            $urandom_range(1) == 1, $urandom_range(3) == 0, bt, jt);
      rst = 1;
    end

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the RISC-V fetch stage: holds the architectural PC and produces the next fetch address each cycle. It generalises the fixed 10-bit PC+4 adder into a registered PC with stall, branch, jump, call/return, configurable width, step and reset vector. A small return-address stack (RAS) is included. It feeds instruction memory and the IF/ID pipeline register.

## Interface
- PC_W, 10, PC and target width in bits
- STEP, 4, sequential increment; power of two, 1 to 2^(PC_W-1)
- RESET_VEC, 0, PC value loaded on reset; multiple of STEP
- RAS_DEPTH, 4, return-address stack entries; power of two, at least 2

- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active low: rst = 0 at a rising edge resets the block
- stall  in  1  hold PC and RAS unchanged
- branch  in  1  take branch_target
- branch_target  in  PC_W  branch destination
- jump  in  1  take jump_target
- call  in  1  qualifies jump: push return address; ignored without jump
- jump_target  in  PC_W  jump/call destination
- ret  in  1  pop the RAS and go to the popped address
- pc  out  PC_W  current fetch address, registered
- pc_next  out  PC_W  pc + STEP mod 2^PC_W, combinational
- misaligned  out  1  registered; set when the loaded pc is not a multiple of STEP
- ras_full, ras_empty  out  1  RAS occupancy, registered
- ras_err  out  1  sticky; overflow or underflow since reset

## Operation
- Priority per edge, highest first: reset, stall, ret, jump (with optional call), branch, sequential.
- Reset: pc = RESET_VEC, misaligned = 0, RAS cleared, ras_empty = 1, ras_full = 0, ras_err = 0.
- stall: pc, misaligned, RAS and flags hold. All other inputs are ignored.
- ret, RAS not empty: pc = top entry; pop.
- ret, RAS empty: pc = pc_next; ras_err = 1. Any simultaneous jump, call or branch is ignored.
- jump: pc = jump_target. With call, push pc_next, which is the return address.
- Push when full: the oldest entry is overwritten (circular), occupancy stays at RAS_DEPTH, and ras_err = 1.
- branch, with no ret or jump: pc = branch_target.
- Otherwise: pc = pc_next.
- Arithmetic: unsigned, modulo 2^PC_W. pc = 2^PC_W - STEP wraps to 0. Targets are loaded unmodified.
- misaligned = (loaded value mod STEP) != 0. It is recomputed on every non-stall load and cleared by sequential steps from aligned values.
- call without jump has no effect. ret together with call: ret wins and nothing is pushed.

## Timing
- Every control input is sampled at the rising edge. The new pc, misaligned value and RAS flags are visible one cycle later, so redirect latency is 1.
- pc_next has zero latency from pc.
- Reset takes effect at the first edge where rst = 0. Reset during a stall or mid-redirect still forces RESET_VEC.
- The RAS push and pc update happen on the same edge. A ret on the next cycle returns the address just pushed.

## Structure
- Shared package pc_pkg holds:
  - the next-PC select enum SEL_HOLD, SEL_RET, SEL_JMP, SEL_BR, SEL_SEQ
  - default parameter constants
  - the log2 depth function used for RAS pointers
- Sub-module pc_ras: circular stack with top pointer and occupancy count. Push, pop, full, empty and overflow/underflow pulses go to pc_unit, which keeps the sticky ras_err.
- pc_unit contains the priority select, the adder, the PC register and the misalignment check.

## Test plan
Defaults for all scenarios: PC_W=10, STEP=4, RESET_VEC=0, RAS_DEPTH=4.

- Reset, then 3 free cycles: pc = 0, 4, 8, 12 with pc_next = pc+4. Drive rst = 0 mid-run: pc = 0 on the next edge with all flags cleared.
- pc = 1020, no control: next pc = 0 (wrap). Stall for 2 cycles at pc = 8: pc stays 8, and branch asserted during the stall is ignored.
- At pc = 16, assert branch and jump together, branch_target = 100, jump_target = 200: pc = 200 (jump wins). A branch alone to 0x3 gives pc = 3 and misaligned = 1; the next sequential step gives pc = 7 and misaligned = 1.
- Call sequence:
  - jump+call to 40 at pc = 8: pc = 40 and 12 is pushed.
  - jump+call to 80 at pc = 40: pc = 80 and 44 is pushed.
  - ret: pc = 44. ret again: pc = 12, ras_empty = 1.
- Five jump+call pushes: ras_full = 1 after the fourth push and ras_err = 1 after the fifth. Four rets then return the last four return addresses in LIFO order.
- ret on an empty RAS at pc = 20: pc = 24 and ras_err = 1, which stays set until reset.
